// File: rtl/load_store_unit.sv
// Load/store unit: turns one core load/store into one or two word-aligned,
// byte-enabled memory beats and returns a single extended response.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, CMD0, WAIT0, CMD1, WAIT1, RESP} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [1:0]        size_reg, size_next;
    logic              write_reg, write_next;
    logic              unsigned_reg, unsigned_next;
    logic              err_reg, err_next;
    logic [2:0]        be1_reg, be1_next;
    logic [31:0]       wdata1_reg, wdata1_next;
    logic [31:0]       rdata0_reg, rdata0_next;
    logic [31:0]       rdata1_reg, rdata1_next;
    logic              mem_valid_reg, mem_valid_next;
    logic              mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [3:0]        mem_be_reg, mem_be_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;

    function automatic logic [6:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [6:0] m;
        case (size)
            2'b01:   m = 7'b0000001;
            2'b10:   m = 7'b0000011;
            2'b11:   m = 7'b0001111;
            default: m = 7'b0000000;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            2'b01:   return 32'h0000_00FF;
            2'b10:   return 32'h0000_FFFF;
            2'b11:   return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Acceptance-time beat geometry, computed straight from the request inputs.
    logic [6:0]  req_mask;
    logic [31:0] req_data;
    logic [4:0]  req_sh0;
    logic [5:0]  req_sh1;
    assign req_mask = lane_mask(req_size, req_addr[1:0]);
    assign req_data = req_wdata & size_mask(req_size);
    assign req_sh0  = {req_addr[1:0], 3'b000};
    assign req_sh1  = 6'd32 - {1'b0, req_addr[1:0], 3'b000};

    logic              two_beats;
    logic [ADDR_W-1:0] base_reg;
    logic [4:0]        sh0_reg;
    logic [5:0]        sh1_reg;
    assign two_beats = |be1_reg;
    assign base_reg  = {addr_reg[ADDR_W-1:2], 2'b00};
    assign sh0_reg   = {addr_reg[1:0], 3'b000};
    assign sh1_reg   = 6'd32 - {1'b0, addr_reg[1:0], 3'b000};

    // Little-endian reassembly; stale beat-1 bytes of a single-beat load fall outside the size mask.
    logic [31:0] load_raw, load_ext;
    always_comb begin
        load_raw = ((rdata0_reg >> sh0_reg) | (rdata1_reg << sh1_reg)) & size_mask(size_reg);
        case (size_reg)
            2'b01:   load_ext = {{24{load_raw[7] & ~unsigned_reg}}, load_raw[7:0]};
            2'b10:   load_ext = {{16{load_raw[15] & ~unsigned_reg}}, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        size_next      = size_reg;
        write_next     = write_reg;
        unsigned_next  = unsigned_reg;
        err_next       = err_reg;
        be1_next       = be1_reg;
        wdata1_next    = wdata1_reg;
        rdata0_next    = rdata0_reg;
        rdata1_next    = rdata1_reg;
        mem_valid_next = mem_valid_reg;
        mem_write_next = mem_write_reg;
        mem_addr_next  = mem_addr_reg;
        mem_be_next    = mem_be_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next     = req_addr;
                    size_next     = req_size;
                    write_next    = req_write;
                    unsigned_next = req_unsigned;
                    err_next      = (req_size == 2'b00);
                    be1_next      = req_mask[6:4];
                    wdata1_next   = req_write ? (req_data >> req_sh1) : 32'h0;
                    if (req_size == 2'b00) begin
                        state_next = RESP;
                    end else begin
                        state_next     = CMD0;
                        mem_valid_next = 1'b1;
                        mem_write_next = req_write;
                        mem_addr_next  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_be_next    = req_mask[3:0];
                        mem_wdata_next = req_write ? (req_data << req_sh0) : 32'h0;
                    end
                end
            end
            CMD0: begin
                if (mem_ready) begin
                    mem_valid_next = 1'b0;
                    if (!write_reg) begin
                        state_next = WAIT0;
                    end else if (two_beats) begin
                        state_next     = CMD1;
                        mem_valid_next = 1'b1;
                        mem_addr_next  = base_reg + ADDR_W'(4);
                        mem_be_next    = {1'b0, be1_reg};
                        mem_wdata_next = wdata1_reg;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
                    rdata0_next = mem_rdata;
                    if (two_beats) begin
                        state_next     = CMD1;
                        mem_valid_next = 1'b1;
                        mem_addr_next  = base_reg + ADDR_W'(4);
                        mem_be_next    = {1'b0, be1_reg};
                        mem_wdata_next = wdata1_reg;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            CMD1: begin
                if (mem_ready) begin
                    mem_valid_next = 1'b0;
                    state_next     = write_reg ? RESP : WAIT1;
                end
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    rdata1_next = mem_rdata;
                    state_next  = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            size_reg      <= '0;
            write_reg     <= 1'b0;
            unsigned_reg  <= 1'b0;
            err_reg       <= 1'b0;
            be1_reg       <= '0;
            wdata1_reg    <= '0;
            rdata0_reg    <= '0;
            rdata1_reg    <= '0;
            mem_valid_reg <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            size_reg      <= size_next;
            write_reg     <= write_next;
            unsigned_reg  <= unsigned_next;
            err_reg       <= err_next;
            be1_reg       <= be1_next;
            wdata1_reg    <= wdata1_next;
            rdata0_reg    <= rdata0_next;
            rdata1_reg    <= rdata1_next;
            mem_valid_reg <= mem_valid_next;
            mem_write_reg <= mem_write_next;
            mem_addr_reg  <= mem_addr_next;
            mem_be_reg    <= mem_be_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    assign req_ready = (state_reg == IDLE) && !rst;
    assign busy      = (state_reg != IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = (state_reg == RESP) && err_reg;
    assign rsp_rdata = (state_reg == RESP && !write_reg && !err_reg) ? load_ext : 32'h0;
    assign mem_valid = mem_valid_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a behavioural word memory answers the
// unit, and each scenario checks per-cycle samples against hand-worked values.
module tb_load_store_unit;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_err, busy;
    logic [31:0]       rsp_rdata;
    logic              mem_valid, mem_ready, mem_write, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Memory behaviour knobs: cycles of ready stall per command, cycles from handshake to rvalid.
    int ready_delay = 0;
    int rv_delay = 1;
    logic [31:0] mem_words [logic [31:0]];
    int          stall_cnt, rv_cnt;
    logic [31:0] rd_pending, merge_w;

    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        stall_cnt = 0; rv_cnt = 0; rd_pending = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_pending;
                end
            end
            if (mem_valid) begin
                if (stall_cnt < ready_delay) begin
                    stall_cnt++;
                    mem_ready = 1'b0;
                end else begin
                    stall_cnt = 0;
                    mem_ready = 1'b1;
                    merge_w = mem_words.exists(mem_addr) ? mem_words[mem_addr] : 32'h0;
                    if (mem_write) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) merge_w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_words[mem_addr] = merge_w;
                    end else begin
                        rd_pending = merge_w;
                        rv_cnt     = rv_delay;
                    end
                end
            end else begin
                mem_ready = 1'b0;
            end
        end
    end

    // Per-cycle samples of one transaction; cycle 0 is the acceptance cycle.
    logic        smp_mv[0:23], smp_mw[0:23], smp_rv[0:23], smp_err[0:23], smp_busy[0:23], smp_ready[0:23];
    logic [31:0] smp_addr[0:23], smp_wd[0:23], smp_rdata[0:23];
    logic [3:0]  smp_be[0:23];

    task automatic sample(input int c);
        smp_mv[c] = mem_valid;   smp_mw[c] = mem_write;  smp_addr[c] = mem_addr;
        smp_be[c] = mem_be;      smp_wd[c] = mem_wdata;  smp_rv[c] = rsp_valid;
        smp_err[c] = rsp_err;    smp_rdata[c] = rsp_rdata;
        smp_busy[c] = busy;      smp_ready[c] = req_ready;
    endtask

    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ncyc, input int rst_at);
        int rc;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        sample(0);
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            sample(c);
            rst = (c == rst_at);
        end
        rc = -1; rd = '0; er = 1'b0;
        for (int c = 0; c <= ncyc; c++)
            if (smp_rv[c] && rc < 0) begin
                rc = c; rd = smp_rdata[c]; er = smp_err[c];
            end
        $display("[TB] txn %s size=%0d uns=%0b addr=0x%08h wdata=0x%08h -> rsp_cycle=%0d rdata=0x%08h err=%0b",
                 wr ? "ST" : "LD", sz, uns, addr, wdata, rc, rd, er);
    endtask

    task automatic test_reset;
        logic [105:0] v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        v = {req_ready, mem_valid, mem_write, mem_addr, mem_be, mem_wdata,
             rsp_valid, rsp_rdata, rsp_err, busy};
        tests_run++;
        if (v !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got 0x%027h, expected all zero", v);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_after: got %0b, expected 1", req_ready);
        end
    endtask

    task automatic test_byte_load;
        mem_words[32'h100] = 32'h80FF1234;
        run_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 6, -1);
        tests_run++;
        if ({smp_mv[1], smp_mw[1], smp_addr[1], smp_be[1]} !== {1'b1, 1'b0, 32'h100, 4'b0100}) begin
            tests_failed++;
            $display("FAIL byte_load_cmd: got v=%0b w=%0b a=0x%08h be=%04b, expected v=1 w=0 a=0x00000100 be=0100",
                     smp_mv[1], smp_mw[1], smp_addr[1], smp_be[1]);
        end
        tests_run++;
        if ({smp_rv[2], smp_rv[3], smp_err[3], smp_rdata[3]} !== {1'b0, 1'b1, 1'b0, 32'hFFFFFFFF}) begin
            tests_failed++;
            $display("FAIL byte_load_signed: got rv2=%0b rv3=%0b err=%0b data=0x%08h, expected 0 1 0 0xffffffff",
                     smp_rv[2], smp_rv[3], smp_err[3], smp_rdata[3]);
        end
        run_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 6, -1);
        tests_run++;
        if ({smp_rv[3], smp_rdata[3]} !== {1'b1, 32'h000000FF}) begin
            tests_failed++;
            $display("FAIL byte_load_unsigned: got rv=%0b data=0x%08h, expected 1 0x000000ff", smp_rv[3], smp_rdata[3]);
        end
    endtask

    task automatic test_aligned_store;
        run_req(1'b1, 2'b11, 1'b0, 32'h200, 32'hDEADBEEF, 5, -1);
        tests_run++;
        if ({smp_mv[1], smp_mw[1], smp_addr[1], smp_be[1], smp_wd[1]} !== {1'b1, 1'b1, 32'h200, 4'b1111, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL store_cmd: got v=%0b w=%0b a=0x%08h be=%04b d=0x%08h, expected 1 1 0x00000200 1111 0xdeadbeef",
                     smp_mv[1], smp_mw[1], smp_addr[1], smp_be[1], smp_wd[1]);
        end
        tests_run++;
        if ({smp_rv[1], smp_rv[2], smp_err[2], smp_rdata[2], smp_mv[2]} !== {1'b0, 1'b1, 1'b0, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL store_rsp: got rv1=%0b rv2=%0b err=%0b data=0x%08h mv2=%0b, expected 0 1 0 0 0",
                     smp_rv[1], smp_rv[2], smp_err[2], smp_rdata[2], smp_mv[2]);
        end
        tests_run++;
        if ({smp_ready[0], smp_ready[2], smp_ready[3], smp_busy[1], smp_busy[2], smp_busy[3]} !== 6'b101110) begin
            tests_failed++;
            $display("FAIL store_ready_busy: got rdy0/2/3=%0b%0b%0b busy1/2/3=%0b%0b%0b, expected 101 110",
                     smp_ready[0], smp_ready[2], smp_ready[3], smp_busy[1], smp_busy[2], smp_busy[3]);
        end
    endtask

    task automatic test_split_store;
        run_req(1'b1, 2'b11, 1'b0, 32'h203, 32'h11223344, 5, -1);
        tests_run++;
        if ({smp_mv[1], smp_addr[1], smp_be[1], smp_wd[1]} !== {1'b1, 32'h200, 4'b1000, 32'h44000000}) begin
            tests_failed++;
            $display("FAIL split_store_beat0: got v=%0b a=0x%08h be=%04b d=0x%08h, expected 1 0x00000200 1000 0x44000000",
                     smp_mv[1], smp_addr[1], smp_be[1], smp_wd[1]);
        end
        tests_run++;
        if ({smp_mv[2], smp_addr[2], smp_be[2], smp_wd[2]} !== {1'b1, 32'h204, 4'b0111, 32'h00112233}) begin
            tests_failed++;
            $display("FAIL split_store_beat1: got v=%0b a=0x%08h be=%04b d=0x%08h, expected 1 0x00000204 0111 0x00112233",
                     smp_mv[2], smp_addr[2], smp_be[2], smp_wd[2]);
        end
        tests_run++;
        if ({smp_rv[2], smp_rv[3], smp_rv[4]} !== 3'b010) begin
            tests_failed++;
            $display("FAIL split_store_rsp: got rv2/3/4=%0b%0b%0b, expected 010", smp_rv[2], smp_rv[3], smp_rv[4]);
        end
    endtask

    task automatic test_store_lanes;
        run_req(1'b1, 2'b01, 1'b0, 32'h301, 32'hFFFFFF5A, 4, -1);
        tests_run++;
        if ({smp_addr[1], smp_be[1], smp_wd[1]} !== {32'h300, 4'b0010, 32'h00005A00}) begin
            tests_failed++;
            $display("FAIL byte_store_lanes: got a=0x%08h be=%04b d=0x%08h, expected 0x00000300 0010 0x00005a00",
                     smp_addr[1], smp_be[1], smp_wd[1]);
        end
        run_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h1234BEEF, 5, -1);
        tests_run++;
        if ({smp_addr[1], smp_be[1], smp_wd[1]} !== {32'hFFFFFFFC, 4'b1000, 32'hEF000000}) begin
            tests_failed++;
            $display("FAIL wrap_store_beat0: got a=0x%08h be=%04b d=0x%08h, expected 0xfffffffc 1000 0xef000000",
                     smp_addr[1], smp_be[1], smp_wd[1]);
        end
        tests_run++;
        if ({smp_mv[2], smp_addr[2], smp_be[2], smp_wd[2], smp_rv[3]} !== {1'b1, 32'h0, 4'b0001, 32'h000000BE, 1'b1}) begin
            tests_failed++;
            $display("FAIL wrap_store_beat1: got v=%0b a=0x%08h be=%04b d=0x%08h rv3=%0b, expected 1 0x00000000 0001 0x000000be 1",
                     smp_mv[2], smp_addr[2], smp_be[2], smp_wd[2], smp_rv[3]);
        end
    endtask

    task automatic test_split_load;
        int n;
        mem_words[32'h0FC] = 32'hAB000000;
        mem_words[32'h100] = 32'h000000CD;
        run_req(1'b0, 2'b10, 1'b0, 32'h0FF, 32'h0, 8, -1);
        tests_run++;
        if ({smp_addr[1], smp_be[1], smp_mv[3], smp_addr[3], smp_be[3]} !== {32'h0FC, 4'b1000, 1'b1, 32'h100, 4'b0001}) begin
            tests_failed++;
            $display("FAIL split_load_beats: got a1=0x%08h be1=%04b v3=%0b a3=0x%08h be3=%04b, expected 0xfc 1000 1 0x100 0001",
                     smp_addr[1], smp_be[1], smp_mv[3], smp_addr[3], smp_be[3]);
        end
        n = 0;
        for (int c = 1; c <= 8; c++) if (smp_rv[c]) n++;
        tests_run++;
        if ({smp_rv[5], smp_rdata[5]} !== {1'b1, 32'hFFFFCDAB} || n != 1) begin
            tests_failed++;
            $display("FAIL split_load_data: got rv5=%0b data=0x%08h pulses=%0d, expected 1 0xffffcdab 1",
                     smp_rv[5], smp_rdata[5], n);
        end
        // Word read back across 0x200/0x204 after the earlier stores.
        run_req(1'b0, 2'b11, 1'b0, 32'h203, 32'h0, 7, -1);
        tests_run++;
        if ({smp_rv[5], smp_rdata[5]} !== {1'b1, 32'h11223344}) begin
            tests_failed++;
            $display("FAIL split_word_load: got rv5=%0b data=0x%08h, expected 1 0x11223344", smp_rv[5], smp_rdata[5]);
        end
    endtask

    task automatic test_backpressure;
        int nb, nr;
        mem_words[32'h400] = 32'h01020304;
        ready_delay = 3;
        rv_delay = 4;
        run_req(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 12, -1);
        ready_delay = 0;
        rv_delay = 1;
        for (int c = 1; c <= 4; c++) begin
            tests_run++;
            if ({smp_mv[c], smp_mw[c], smp_addr[c], smp_be[c], smp_wd[c]} !== {1'b1, 1'b0, 32'h400, 4'b1111, 32'h0}) begin
                tests_failed++;
                $display("FAIL bp_hold_c%0d: got v=%0b w=%0b a=0x%08h be=%04b d=0x%08h, expected 1 0 0x00000400 1111 0",
                         c, smp_mv[c], smp_mw[c], smp_addr[c], smp_be[c], smp_wd[c]);
            end
        end
        nb = 0; nr = 0;
        for (int c = 1; c <= 12; c++) begin
            if (smp_busy[c]) nb++;
            if (smp_rv[c]) nr++;
        end
        tests_run++;
        if (nb != 9 || nr != 1 || smp_mv[5] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_busy_pulses: got busy_cycles=%0d rsp_pulses=%0d mv5=%0b, expected 9 1 0", nb, nr, smp_mv[5]);
        end
        tests_run++;
        if ({smp_rv[9], smp_rdata[9], smp_busy[9], smp_busy[10]} !== {1'b1, 32'h01020304, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL bp_rsp: got rv9=%0b data=0x%08h busy9=%0b busy10=%0b, expected 1 0x01020304 1 0",
                     smp_rv[9], smp_rdata[9], smp_busy[9], smp_busy[10]);
        end
    endtask

    task automatic test_reset_abort;
        int nr;
        rv_delay = 3;
        run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 8, 2);
        rv_delay = 1;
        tests_run++;
        if ({smp_busy[2], smp_mv[2]} !== 2'b10) begin
            tests_failed++;
            $display("FAIL abort_in_wait: got busy2=%0b mv2=%0b, expected 1 0", smp_busy[2], smp_mv[2]);
        end
        tests_run++;
        if ({smp_ready[3], smp_busy[3], smp_mv[3], smp_mw[3], smp_addr[3], smp_be[3], smp_wd[3],
             smp_rv[3], smp_rdata[3], smp_err[3]} !== '0) begin
            tests_failed++;
            $display("FAIL abort_reset_vals: got rdy=%0b busy=%0b mv=%0b mw=%0b a=0x%08h be=%04b d=0x%08h rv=%0b data=0x%08h err=%0b, expected all 0",
                     smp_ready[3], smp_busy[3], smp_mv[3], smp_mw[3], smp_addr[3], smp_be[3], smp_wd[3],
                     smp_rv[3], smp_rdata[3], smp_err[3]);
        end
        nr = 0;
        for (int c = 1; c <= 8; c++) if (smp_rv[c]) nr++;
        tests_run++;
        if (nr != 0 || {smp_ready[5], smp_busy[5], smp_mv[5]} !== 3'b100) begin
            tests_failed++;
            $display("FAIL abort_late_rvalid: got rsp_pulses=%0d rdy5=%0b busy5=%0b mv5=%0b, expected 0 1 0 0",
                     nr, smp_ready[5], smp_busy[5], smp_mv[5]);
        end
    endtask

    task automatic test_illegal;
        int nm;
        run_req(1'b0, 2'b00, 1'b0, 32'h500, 32'h0, 4, -1);
        tests_run++;
        if ({smp_rv[1], smp_err[1], smp_rdata[1]} !== {1'b1, 1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL illegal_rsp: got rv=%0b err=%0b data=0x%08h, expected 1 1 0", smp_rv[1], smp_err[1], smp_rdata[1]);
        end
        nm = 0;
        for (int c = 0; c <= 4; c++) if (smp_mv[c]) nm++;
        tests_run++;
        if (nm != 0 || {smp_ready[1], smp_ready[2], smp_rv[2]} !== 3'b010) begin
            tests_failed++;
            $display("FAIL illegal_no_traffic: got mv_cycles=%0d rdy1=%0b rdy2=%0b rv2=%0b, expected 0 0 1 0",
                     nm, smp_ready[1], smp_ready[2], smp_rv[2]);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rst = 1'b1;
        test_reset();
        test_byte_load();
        test_aligned_store();
        test_split_store();
        test_store_lanes();
        test_split_load();
        test_backpressure();
        test_reset_abort();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the data memory. It accepts one load or store per handshake from the execute stage, using the codebase size encoding (01 byte, 10 half, 11 word). It issues word-aligned, byte-enabled requests to a word-wide data memory, and splits any access that crosses a word boundary into two beats. For loads it reassembles the bytes little-endian and sign- or zero-extends them, then returns one response per request to writeback.

## Interface
- ADDR_W, 32, byte-address width; data fixed at 32 bits
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  high only in IDLE and not in reset; request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  01 byte, 10 half, 11 word, 00 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address, any alignment
- req_wdata  in  32  store data, LSB-justified
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid; set for size 00
- busy  out  1  high from acceptance until the rsp_valid cycle inclusive (core stall)
- mem_valid  out  1  memory command valid
- mem_ready  in  1  memory accepts the command
- mem_write  out  1  command is a write
- mem_addr  out  ADDR_W  word-aligned address, [1:0] = 0
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-aligned write data; disabled lanes 0
- mem_rvalid  in  1  read data return, at least 1 cycle after acceptance
- mem_rdata  in  32  read data

## Operation
- Acceptance latches addr, size, write, unsigned and wdata. Let off = addr[1:0] and base = addr & ~3.
- Lane mask is byte 0001, half 0011, word 1111, shifted left by off within a 7-bit field.
  - Beat0 mask = bits [3:0]; beat1 mask = bits [6:4].
  - Two beats are needed when beat1 mask != 0: half at off 3, or word at off 1..3.
- Beat0 uses mem_addr = base and mem_wdata = wdata << 8*off.
- Beat1 uses mem_addr = base+4 (wraps modulo 2^ADDR_W) and mem_wdata = wdata >> 8*(4-off).
- Load assembly: raw = (beat0 rdata >> 8*off) | (beat1 rdata << 8*(4-off)). Mask raw to the access size, then extend from bit 7 or bit 15 unless req_unsigned. Words are not extended.
- FSM states: IDLE, CMD0, WAIT0, CMD1, WAIT1, RESP.
  - IDLE: on acceptance go to CMD0, or straight to RESP with rsp_err = 1 when size = 00 (no memory traffic).
  - CMDn: mem_valid = 1. On mem_ready, a write goes to CMD1 if a second beat is needed, else RESP. A read goes to WAITn.
  - WAITn: on mem_rvalid, capture the data. Go to CMD1 from WAIT0 if a second beat is needed, else RESP.
  - RESP: rsp_valid = 1 for one cycle, then IDLE.
- mem_rvalid outside the WAIT states is ignored. Only one memory command is ever outstanding.
- mem_valid, mem_addr, mem_be, mem_write and mem_wdata are registered. They are held stable while mem_valid && !mem_ready.

## Timing
- Reset: state IDLE. mem_valid, mem_write, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, rsp_err and busy are all 0. req_ready is 0 during the reset cycle and 1 afterwards.
- Aligned store with mem_ready = 1: accept at cycle 0, mem_valid at 1, rsp_valid at 2, req_ready at 3.
- Aligned load with mem_ready = 1 and rvalid one cycle after the command: accept 0, command 1, rvalid 2, rsp_valid 3.
- A split access adds 1 cycle for a store and 2 cycles for a load, plus any memory wait.
- Illegal size: accept 0, rsp_valid with rsp_err at 1.
- Reset in any state: IDLE on the next edge. mem_valid drops and no rsp_valid is issued for the aborted request. A late mem_rvalid after reset is ignored.
- A second request cannot be accepted in the rsp_valid cycle. A request can be accepted on the cycle after it.

## Test plan
- Signed byte load, addr 0x102, word@0x100 = 0x80FF1234:
  - One beat with be 0100.
  - rsp_rdata 0xFFFFFFFF.
  - Repeating with req_unsigned = 1 gives 0x000000FF.
- Aligned word store, addr 0x200, data 0xDEADBEEF, mem_ready tied 1:
  - mem_addr 0x200, be 1111, wdata 0xDEADBEEF at cycle 1.
  - rsp_valid at cycle 2.
- Misaligned word store, addr 0x203, data 0x11223344:
  - Beat0: addr 0x200, be 1000, wdata 0x44000000.
  - Beat1: addr 0x204, be 0111, wdata 0x00112233.
- Misaligned signed half load, addr 0x0FF, word@0x0FC = 0xAB000000, word@0x100 = 0x000000CD:
  - Beats at 0x0FC (be 1000) and 0x100 (be 0001).
  - rsp_rdata 0xFFFFCDAB.
- Backpressure: mem_ready low for 3 cycles, then rvalid 4 cycles later:
  - Command payload is stable throughout.
  - busy stays high.
  - Exactly one rsp_valid.
- Reset and error cases:
  - Assert rst in WAIT0, then pulse mem_rvalid: no rsp_valid, outputs at reset values.
  - Next request, size 00: rsp_valid with rsp_err = 1 at cycle 1, and mem_valid never asserted.
